// File: rtl/pool_pkg.sv
// pool_pkg: shared geometry, state encoding and FIFO word layout for the pooled buffer reader
package pool_pkg;
    localparam int POOL_SIZE_COL = 7;
    localparam int POOL_SIZE_ROW = 28;
    localparam int POOL_ADDR_COL = 3;
    localparam int POOL_ADDR_ROW = 5;
    localparam int DATA_W = 16;
    localparam logic [POOL_ADDR_COL-1:0] COL_LAST = POOL_ADDR_COL'(POOL_SIZE_COL - 1);
    localparam logic [POOL_ADDR_ROW-1:0] ROW_LAST = POOL_ADDR_ROW'(POOL_SIZE_ROW - 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pool_state_t;
    typedef struct packed {
        logic [DATA_W-1:0]        data;
        logic [POOL_ADDR_COL-1:0] col;
        logic [POOL_ADDR_ROW-1:0] row;
        logic                     last;
    } pool_word_t;
endpackage

// File: rtl/pool_skid_fifo.sv
// pool_skid_fifo: 2-entry FIFO holding tagged buffer words between read return and the output stream
module pool_skid_fifo
    import pool_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  pool_word_t push_word,
    output pool_word_t head,
    output logic [1:0] count
);
    pool_word_t mem_q [2];
    pool_word_t mem_d [2];
    logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // next-state: write at wr_ptr, advance pointers on push/pop, push+pop leaves the count unchanged
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = push_word;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    // storage and pointers; reset flushes everything so the head reads as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            assert (!(push && !pop && count_q == 2'd2));
            assert (!(pop && count_q == 2'd0));
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/pooled_buf_reader.sv
// pooled_buf_reader: walks the pooled buffer row-major and streams tagged words over valid/ready
module pooled_buf_reader
    import pool_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     rd_en,
    output logic [POOL_ADDR_COL-1:0] rd_col,
    output logic [POOL_ADDR_ROW-1:0] rd_row,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [POOL_ADDR_COL-1:0] out_col,
    output logic [POOL_ADDR_ROW-1:0] out_row,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    pool_state_t              state_q, state_d;
    logic [POOL_ADDR_COL-1:0] col_q, col_d, tag_col_q, tag_col_d;
    logic [POOL_ADDR_ROW-1:0] row_q, row_d, tag_row_q, tag_row_d;
    logic                     tag_last_q, tag_last_d, inflight_q, inflight_d;
    logic                     pop, final_addr;
    logic [1:0]               fifo_count, occ;
    pool_word_t               head, push_word;

    assign final_addr = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign out_valid  = fifo_count != 2'd0;
    assign pop        = out_valid & out_ready;
    assign occ        = fifo_count + {1'b0, inflight_q};
    assign rd_col     = col_q;
    assign rd_row     = row_q;
    assign out_data   = head.data;
    assign out_col    = head.col;
    assign out_row    = head.row;
    assign out_last   = head.last;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = state_q == DONE;
    assign push_word  = '{data: rd_data, col: tag_col_q, row: tag_row_q, last: tag_last_q};

    // sequencer: a read is issued only while the FIFO plus the in-flight word leaves a free slot
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        rd_en      = (state_q == RUN) && (occ < 2'd2 || pop);
        inflight_d = rd_en;
        tag_col_d  = col_q;
        tag_row_d  = row_q;
        tag_last_d = final_addr;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                col_d   = '0;
                row_d   = '0;
            end
            RUN: if (rd_en) begin
                if (final_addr) state_d = DRAIN;
                else begin
                    col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                    row_d = (col_q == COL_LAST) ? row_q + 1'b1 : row_q;
                end
            end
            DRAIN: if (pop && head.last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // state, address counter, and the tag of the read whose data returns next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= 1'b0;
            tag_col_q  <= '0;
            tag_row_q  <= '0;
            tag_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= inflight_d;
            tag_col_q  <= tag_col_d;
            tag_row_q  <= tag_row_d;
            tag_last_q <= tag_last_d;
        end
    end

    pool_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .pop       (pop),
        .push_word (push_word),
        .head      (head),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_pooled_buf_reader.sv
// tb_pooled_buf_reader: directed bench with a buffer model and a row-major stream scoreboard
module tb_pooled_buf_reader;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic        rd_en, out_valid, out_last, busy, done;
    logic [2:0]  rd_col, out_col;
    logic [4:0]  rd_row, out_row;
    logic [15:0] rd_data = '0, out_data;
    int          checks = 0, failures = 0, rd_idx = 0, hs_idx = 0;
    logic        last_hs_q = 1'b0, stalled_q = 1'b0;
    logic [25:0] held = '0;

    pooled_buf_reader dut (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_row(out_row), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // buffer model: word at (row,col) is row*8+col, returned one cycle after rd_en
    always @(posedge clk) if (rd_en) rd_data <= 16'(int'(rd_row) * 8 + int'(rd_col));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic p;
        p = out_valid && out_ready;
        chk("done_after_last", done, last_hs_q);
        if (done) chk("done_quiet", {busy, out_valid}, 0);
        if (stalled_q) chk("head_hold", {out_valid, out_data, out_row, out_col, out_last}, {1'b1, held[24:0]});
        if (rd_en) begin
            chk("rd_addr", {rd_row, rd_col}, {5'(rd_idx / 7), 3'(rd_idx % 7)});
            chk("credit", (rd_idx - hs_idx - int'(p)) < 2, 1);
            rd_idx++;
        end
        if (p) begin
            chk("beat", {out_row, out_col, out_data, out_last},
                {5'(hs_idx / 7), 3'(hs_idx % 7), 16'((hs_idx / 7) * 8 + hs_idx % 7), hs_idx == 195});
            hs_idx++;
        end
        last_hs_q = p && out_last;
        stalled_q = out_valid && !out_ready;
        held = {out_valid, out_data, out_row, out_col, out_last};
    endtask

    task automatic step(input logic rst, input logic s, input logic r);
        @(posedge clk);
        #1;
        reset = rst;
        start = s;
        out_ready = r;
        @(negedge clk);
        if (rst) begin
            rd_idx = 0;
            hs_idx = 0;
            last_hs_q = 1'b0;
            stalled_q = 1'b0;
        end else monitor();
    endtask

    task automatic new_pass(input logic r);
        rd_idx = 0;
        hs_idx = 0;
        last_hs_q = 1'b0;
        stalled_q = 1'b0;
        step(0, 1, r);
        chk("idle_at_start", {busy, rd_en, done}, 0);
    endtask

    task automatic run_to_done(input int mode);
        logic r;
        for (int c = 0; c < 3000; c++) begin
            r = (mode == 0) ? 1'b1 : (mode == 2 && c >= 40 && c < 50) ? 1'b0 : 1'($urandom_range(0, 1));
            step(0, 0, r);
            if (done) break;
        end
        chk("pass_end_done", done, 1);
        chk("pass_end_words", hs_idx, 196);
    endtask

    initial begin
        repeat (3) step(1, 0, 0);
        step(0, 0, 0);
        chk("reset_outputs", {rd_en, rd_col, rd_row, out_valid, out_data, out_col, out_row, out_last, busy, done}, 0);
        step(0, 0, 0);
        chk("idle_quiet", {busy, rd_en, out_valid, done}, 0);

        new_pass(1);
        step(0, 0, 1);
        chk("first_rd", {rd_en, out_valid, busy}, 3'b101);
        step(0, 0, 1);
        chk("latency_gap", {rd_en, out_valid}, 2'b10);
        step(0, 0, 1);
        chk("first_word", {out_valid, out_row, out_col, out_data}, {1'b1, 5'd0, 3'd0, 16'd0});
        for (int i = 1; i < 196; i++) begin
            step(0, 0, 1);
            chk("full_rate_valid", out_valid, 1);
            if (i == 7) chk("row_wrap", {out_row, out_col, out_data, out_last}, {5'd1, 3'd0, 16'd8, 1'b0});
            if (i == 195) chk("last_word", {out_last, out_row, out_col, out_data, busy}, {1'b1, 5'd27, 3'd6, 16'd222, 1'b1});
        end
        step(0, 0, 1);
        chk("done_pulse", {done, busy, out_valid}, 3'b100);
        step(0, 0, 1);
        chk("done_single", {done, busy}, 0);

        new_pass(0);
        run_to_done(2);

        new_pass(1);
        for (int c = 0; c < 1000 && hs_idx < 195; c++) step(0, c == 10, 1);
        chk("pre_stall", hs_idx, 195);
        for (int i = 0; i < 5; i++) begin
            step(0, i == 2, 0);
            chk("end_stall", {busy, done, out_valid, out_last}, 4'b1011);
        end
        step(0, 0, 1);
        step(0, 1, 1);
        chk("done_after_stall", {done, busy}, 2'b10);
        chk("one_pass", hs_idx, 196);
        new_pass(1);
        run_to_done(0);

        new_pass(1);
        for (int c = 0; c < 1000 && hs_idx < 50; c++) step(0, 0, 1);
        chk("reached_50", hs_idx, 50);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("fifo_full_stall", {out_valid, rd_en}, 2'b10);
        step(1, 0, 0);
        step(0, 0, 1);
        chk("reset_mid_pass", {out_valid, busy, rd_en, rd_row, rd_col, done}, 0);
        step(0, 0, 1);
        chk("no_stale_word", {out_valid, busy}, 0);
        new_pass(0);
        run_to_done(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pooled_buf_reader.md
Name: pooled_buf_reader

Overview:
- Read-side sequencer for the pooled feature buffer (POOL_SIZE_ROW x POOL_SIZE_COL words) that the pooling write counter fills.
- On start, it walks the buffer in row-major order: row 0..POOL_SIZE_ROW-1, and col 0..POOL_SIZE_COL-1 within each row.
- It issues one read address per word, absorbs the buffer's 1-cycle read latency, and streams the words to the next layer over a valid/ready interface.
- Each word is tagged with its coordinates and a last flag.

Parameters:
- POOL_SIZE_COL, 7, columns in pooled buffer.
- POOL_SIZE_ROW, 28, rows in pooled buffer.
- POOL_ADDR_COL, 3, column address width.
- POOL_ADDR_ROW, 5, row address width.
- DATA_W, 16, buffer word width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin one full buffer pass; honoured only in IDLE.
- rd_en  out  1  buffer read strobe.
- rd_col  out  POOL_ADDR_COL  read column address.
- rd_row  out  POOL_ADDR_ROW  read row address.
- rd_data  in  DATA_W  buffer data, valid the cycle after rd_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  stream word.
- out_col  out  POOL_ADDR_COL  column tag of out_data.
- out_row  out  POOL_ADDR_ROW  row tag of out_data.
- out_last  out  1  high with word (POOL_SIZE_ROW-1, POOL_SIZE_COL-1).
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (synchronous, active-high, clk edge with reset=1): all outputs 0, state IDLE, address counters 0, in-flight flag cleared, FIFO flushed. This applies at any time, including mid-pass; no partial words are emitted after reset.
- States:
  - IDLE: start=1 -> RUN, counters set to (0,0).
  - RUN: issue reads. The final address (POOL_SIZE_ROW-1, POOL_SIZE_COL-1) is issued -> DRAIN.
  - DRAIN: no new reads. The final word is handshaken -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in RUN and DRAIN.
- start outside IDLE is ignored. start in DONE is ignored. start in IDLE the cycle after DONE is honoured.
- Read issue:
  - In RUN, rd_en=1 iff credit>0, where credit = 2 - fifo_count - inflight + pop, and pop = out_valid & out_ready.
  - rd_col/rd_row show the current counter value. They are driven from the counter directly, not registered separately, and hold when rd_en=0.
  - The counter advances only when rd_en=1. col increments; at col==POOL_SIZE_COL-1 it wraps to 0 and row increments.
  - The counter is never advanced past the final address.
- Capture:
  - inflight register = rd_en of the previous cycle.
  - When inflight=1, rd_data plus the registered address tag of that read are pushed into a 2-entry FIFO.
  - The credit rule guarantees the FIFO never overflows. An overflow is an assertion failure.
- Output:
  - The FIFO head drives out_data/out_col/out_row/out_last. out_valid = FIFO non-empty.
  - Head fields are held stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle is legal at any occupancy (0, 1 or 2 with pop).
- Latency: start sampled at edge T -> first rd_en in cycle T+1 -> FIFO push at edge T+2 -> out_valid first high in cycle T+2 after that edge (i.e. 2 cycles after start).
- Throughput: with out_ready held high, one word per cycle. A pass is POOL_SIZE_ROW*POOL_SIZE_COL = 196 words.
- done: asserted in the cycle after the handshake of the out_last word. No out_valid while done=1.
- Widths: counter compares use parameters minus 1; no arithmetic beyond +1 increments. The FIFO count is 2 bits.

Decomposition:
- Shared package (pool_pkg): POOL_SIZE_COL, POOL_SIZE_ROW, POOL_ADDR_COL, POOL_ADDR_ROW, DATA_W, plus the state encoding enum (IDLE, RUN, DRAIN, DONE).
- One sub-module: pool_skid_fifo, a 2-entry FIFO of {data, col, row, last} with push, pop, count, head outputs, and synchronous active-high reset.

Test Plan:
- Reset check: reset high 3 cycles, then low -> all outputs 0, busy=0, no rd_en.
- Full-rate pass:
  - Stimulus: buffer model returns data = row*8+col; out_ready=1; start pulse.
  - Required: rd_en first high the cycle after start; out_valid 2 cycles after start; 196 consecutive beats in row-major order with matching tags.
  - Required: beat 7 is (1,0) data 8 (row wrap); out_last only on (27,6) data 222; done pulse exactly 1 cycle later; busy falls with done.
- Backpressure:
  - Stimulus: out_ready random 50%, plus a stretch held low 10 cycles mid-row.
  - Required: no rd_en while credit is 0; head stable while stalled; no loss or duplication; the full 196-word sequence matches.
- Start robustness: start re-pulsed in RUN, in DRAIN and in DONE -> ignored, exactly one pass. start in IDLE right after done -> second full pass.
- Reset mid-pass: assert reset at word 50 with FIFO holding 2 entries -> next cycle out_valid=0, busy=0, counters 0. A new start re-reads from (0,0).
- Stall at end: out_ready=0 when out_last becomes valid for 5 cycles -> state stays DRAIN, done=0. Raising ready -> handshake, then done the cycle after.
